fifo_read_sched: RTL

FIFO_READ_SCHED -- requirements
Module: fifo_read_sched

---
 rtl/fifo_read_sched.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_read_sched.sv
// fifo_read_sched: reads bursts of words from a FIFO and hands them one at a time to a PIC.
// Ports:
//   CLK, Reset      - clock (rising edge) and async active-high reset
//   AF, AE, EF, FF  - FIFO almost-full / almost-empty / empty / full flags
//   fifo_dout       - FIFO read data, valid one cycle after fifo_ren
//   pic_start       - PIC grants a burst while irq is high
//   pic_ack         - PIC has taken data_out
//   clr_ovf         - clears the sticky overflow flag
//   fifo_ren        - FIFO read strobe
//   data_out        - word presented to the PIC, data_valid while unacknowledged
//   irq             - service request (REQ state)
//   busy            - burst in progress
//   word_cnt        - words moved in the current or last burst (saturating)
//   ovf             - sticky FIFO-full indication
module fifo_read_sched #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              AF,
    input  logic              AE,
    input  logic              EF,
    input  logic              FF,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              pic_start,
    input  logic              pic_ack,
    input  logic              clr_ovf,
    output logic              fifo_ren,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              irq,
    output logic              busy,
    output logic [7:0]        word_cnt,
    output logic              ovf
);
    typedef enum logic [2:0] {IDLE, REQ, READ, FETCH, HOLD} state_t;
    state_t state, state_nx;
    logic af_q, ae_q, primed;
    logic af_rise, ae_rise, last_word;
    // primed keeps the first post-reset AF sample from counting as an edge
    assign af_rise   = AF & ~af_q & primed;
    assign ae_rise   = AE & ~ae_q;
    assign last_word = (word_cnt == 8'(BURST_LEN)) || EF;
    assign fifo_ren  = (state == READ) && !EF;
    assign irq       = state == REQ;
    assign busy      = (state == READ) || (state == FETCH) || (state == HOLD);
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = af_rise ? REQ : IDLE;
            REQ:     state_nx = ae_rise ? IDLE : pic_start ? READ : REQ;
            READ:    state_nx = EF ? IDLE : FETCH;
            FETCH:   state_nx = HOLD;
            HOLD:    state_nx = !pic_ack ? HOLD : last_word ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            af_q       <= 1'b0;
            ae_q       <= 1'b0;
            primed     <= 1'b0;
            ovf        <= 1'b0;
            word_cnt   <= 8'd0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            af_q   <= AF;
            ae_q   <= AE;
            primed <= 1'b1;
            // FF wins over a coincident clear
            ovf    <= FF | (ovf & ~clr_ovf);
            if (state == REQ && state_nx == READ) word_cnt <= 8'd0;
            if (state == FETCH) begin
                data_out   <= fifo_dout;
                data_valid <= 1'b1;
                word_cnt   <= (word_cnt == 8'hFF) ? word_cnt : word_cnt + 8'd1;
            end
            if (state == HOLD && pic_ack) data_valid <= 1'b0;
        end
    end
endmodule
